// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_schedule
// Purpose  : SHA-256 message schedule; streams W[0..63] from one 16-word block
//            through a 16-entry sliding window with valid/ready handshakes.
// Revision : 1.0  initial release
// ============================================================================
module sha256_msg_schedule (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        msg_valid,
   input  logic [31:0] msg_word,
   output logic        msg_ready,
   output logic        w_valid,
   output logic [31:0] w_out,
   output logic [5:0]  w_idx,
   input  logic        w_ready,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_EXPAND = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   localparam logic [6:0] c_LAST_MSG = 7'd15;
   localparam logic [6:0] c_LAST_W   = 7'd63;

   state_t      r_state;
   logic [31:0] r_win [0:15];
   logic [6:0]  r_t;
   logic [31:0] r_w_out;
   logic [5:0]  r_w_idx;
   logic        r_w_valid;
   logic        r_done;

   logic        w_out_free;
   logic        w_load_msg;
   logic        w_load_exp;
   logic        w_load;
   logic        w_w_xfer;
   logic [31:0] w_expand;
   logic [31:0] w_next_word;

   function automatic logic [31:0] f_sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] f_sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   assign w_out_free  = !r_w_valid || w_ready;
   assign w_load_msg  = (r_state == S_LOAD) && w_out_free && msg_valid;
   assign w_load_exp  = (r_state == S_EXPAND) && w_out_free;
   assign w_load      = w_load_msg || w_load_exp;
   assign w_w_xfer    = r_w_valid && w_ready;
   // win[0] = W[t-16], win[1] = W[t-15], win[9] = W[t-7], win[14] = W[t-2]
   assign w_expand    = f_sigma1(r_win[14]) + r_win[9] + f_sigma0(r_win[1]) + r_win[0];
   assign w_next_word = w_load_msg ? msg_word : w_expand;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_t       <= 7'd0;
         r_w_out   <= 32'd0;
         r_w_idx   <= 6'd0;
         r_w_valid <= 1'b0;
         r_done    <= 1'b0;
         for (int i = 0; i < 16; i++) r_win[i] <= 32'd0;
      end else begin
         r_done <= 1'b0;

         if (w_load) begin
            r_w_out   <= w_next_word;
            r_w_idx   <= r_t[5:0];
            r_w_valid <= 1'b1;
            r_t       <= r_t + 7'd1;
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= w_next_word;
         end else if (w_w_xfer) begin
            r_w_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_LOAD;
                  r_t     <= 7'd0;
               end
            end
            S_LOAD: begin
               if (w_load_msg && (r_t == c_LAST_MSG)) r_state <= S_EXPAND;
            end
            S_EXPAND: begin
               if (w_load_exp && (r_t == c_LAST_W)) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_w_xfer) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign msg_ready = (r_state == S_LOAD) && w_out_free;
   assign w_valid   = r_w_valid;
   assign w_out     = r_w_out;
   assign w_idx     = r_w_idx;
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_schedule
// Purpose  : Scoreboard bench for sha256_msg_schedule against a direct
//            array-based SHA-256 schedule model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sha256_msg_schedule;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        msg_valid = 1'b0;
   logic [31:0] msg_word = 32'd0;
   logic        msg_ready;
   logic        w_valid;
   logic [31:0] w_out;
   logic [5:0]  w_idx;
   logic        w_ready = 1'b0;
   logic        busy;
   logic        done;

   int          checks = 0;
   int          failures = 0;
   int          ready_mode = 1;     // 0 low, 1 high, 2 random
   bit          mon_en = 1'b0;
   int          cyc = 0;
   int          xfer_cnt = 0;
   logic [37:0] exp_q [$];
   logic [37:0] exp_e;
   logic [31:0] cap [64];
   int          xfer_cyc [64];
   bit          stall_prev = 1'b0;
   logic [31:0] prev_out;
   logic [5:0]  prev_idx;

   sha256_msg_schedule dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .msg_valid (msg_valid),
      .msg_word  (msg_word),
      .msg_ready (msg_ready),
      .w_valid   (w_valid),
      .w_out     (w_out),
      .w_idx     (w_idx),
      .w_ready   (w_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       w_ready = 1'b0;
         1:       w_ready = 1'b1;
         default: w_ready = ($urandom_range(0, 2) != 0);
      endcase
   end

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   function automatic void model(input logic [31:0] m [16], output logic [31:0] w [64]);
      for (int t = 0; t < 64; t++) begin
         if (t < 16) w[t] = m[t];
         else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                   + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      end
   endfunction

   // Scoreboard consumer: transfers pop the queue, stalls must hold the output
   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         if (stall_prev) begin
            checks++;
            if (w_out !== prev_out || w_idx !== prev_idx) begin
               failures++;
               $display("FAIL stall_hold got=%h/%0d exp=%h/%0d", w_out, w_idx, prev_out, prev_idx);
            end
         end
         stall_prev = w_valid && !w_ready;
         prev_out   = w_out;
         prev_idx   = w_idx;
         if (w_valid && w_ready) begin
            checks++;
            xfer_cnt++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL extra_word got=%h idx=%0d", w_out, w_idx);
            end else begin
               exp_e = exp_q.pop_front();
               if ({w_idx, w_out} !== exp_e) begin
                  failures++;
                  $display("FAIL word got idx=%0d w=%h exp idx=%0d w=%h", w_idx, w_out, exp_e[37:32], exp_e[31:0]);
               end
               cap[w_idx]      = w_out;
               xfer_cyc[w_idx] = cyc;
            end
         end
      end else begin
         stall_prev = 1'b0;
      end
   end

   // All tasks enter and leave one time unit after a rising edge.
   task automatic send_block(input logic [31:0] m [16], input bit do_start, input bit gaps,
                             input bit start_in_load);
      logic [31:0] w [64];
      bit acc;
      int n;
      model(m, w);
      for (int i = 0; i < 64; i++) exp_q.push_back({i[5:0], w[i]});
      xfer_cnt = 0;
      if (do_start) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               msg_valid = 1'b0;
               msg_word  = $urandom;
               @(posedge clk); #1;
            end
         end
         msg_valid = 1'b1;
         msg_word  = m[i];
         if (start_in_load && i == 5) start = 1'b1;
         n = 0;
         do begin
            @(negedge clk);
            acc = msg_ready;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
         end while (!acc && n < 200);
         if (!acc) begin
            checks++;
            failures++;
            $display("FAIL msg_timeout word=%0d got=no_accept exp=accept", i);
            msg_valid = 1'b0;
            return;
         end
      end
      msg_valid = 1'b0;
      msg_word  = $urandom;
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int n = 0; n < 600 && !seen; n++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset();
      ready_mode = 2;
      for (int i = 0; i < 6; i++) begin
         start     = $urandom_range(0, 1);
         msg_valid = $urandom_range(0, 1);
         msg_word  = $urandom;
         @(negedge clk);
         checks++;
         if ({w_valid, w_out, w_idx, msg_ready, busy, done} !== 42'd0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b w=%h i=%0d mr=%b b=%b d=%b exp=all_zero",
                     w_valid, w_out, w_idx, msg_ready, busy, done);
         end
         @(posedge clk); #1;
      end
      start = 1'b0; msg_valid = 1'b1; rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || msg_ready !== 1'b0 || w_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset got b=%b mr=%b v=%b exp=0/0/0", busy, msg_ready, w_valid);
      end
      @(posedge clk); #1;
      msg_valid = 1'b0;
      ready_mode = 1;
      mon_en = 1'b1;
   endtask

   task automatic test_abc();
      logic [31:0] m [16];
      bit seen;
      for (int i = 0; i < 16; i++) m[i] = 32'd0;
      m[0] = 32'h61626380; m[15] = 32'h00000018;
      ready_mode = 1;
      send_block(m, 1'b1, 1'b0, 1'b0);
      wait_done(seen);
      checks++;
      if (!seen || busy !== 1'b0 || xfer_cnt != 64 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL abc_end got done=%b busy=%b xfers=%0d left=%0d exp=1/0/64/0", seen, busy, xfer_cnt, exp_q.size());
      end
      checks++;
      if (cap[16] !== 32'h61626380 || cap[17] !== 32'h000F0000 ||
          cap[18] !== 32'h7DA86405 || cap[19] !== 32'h600003C6) begin
         failures++;
         $display("FAIL abc_w16_19 got=%h %h %h %h exp=61626380 000f0000 7da86405 600003c6",
                  cap[16], cap[17], cap[18], cap[19]);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse got=%b exp=0", done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_zero_timing();
      logic [31:0] m [16];
      bit seen;
      for (int i = 0; i < 16; i++) m[i] = 32'd0;
      ready_mode = 1;
      send_block(m, 1'b1, 1'b0, 1'b0);
      wait_done(seen);
      checks++;
      if (!seen || xfer_cnt != 64 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL zero_end got done=%b xfers=%0d left=%0d exp=1/64/0", seen, xfer_cnt, exp_q.size());
      end
      checks++;
      if (xfer_cyc[63] - xfer_cyc[15] != 48) begin
         failures++;
         $display("FAIL zero_latency got=%0d exp=48", xfer_cyc[63] - xfer_cyc[15]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random(input string name, input bit all_ones, input int mode, input bit gaps);
      logic [31:0] m [16];
      bit seen;
      for (int i = 0; i < 16; i++) m[i] = all_ones ? 32'hFFFFFFFF : $urandom;
      ready_mode = mode;
      send_block(m, 1'b1, gaps, 1'b0);
      wait_done(seen);
      checks++;
      if (!seen || xfer_cnt != 64 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_end got done=%b xfers=%0d left=%0d exp=1/64/0", name, seen, xfer_cnt, exp_q.size());
      end
      @(posedge clk); #1;
      ready_mode = 1;
   endtask

   task automatic test_start_ignored();
      logic [31:0] m [16];
      bit seen;
      for (int i = 0; i < 16; i++) m[i] = $urandom;
      ready_mode = 1;
      send_block(m, 1'b1, 1'b0, 1'b1);
      repeat (5) begin @(posedge clk); #1; end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(seen);
      checks++;
      if (!seen || xfer_cnt != 64 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL start_ignored_end got done=%b xfers=%0d left=%0d exp=1/64/0", seen, xfer_cnt, exp_q.size());
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL start_ignored_idle got busy=%b exp=0", busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [31:0] m1 [16];
      logic [31:0] m2 [16];
      bit seen;
      for (int i = 0; i < 16; i++) begin m1[i] = $urandom; m2[i] = $urandom; end
      ready_mode = 1;
      send_block(m1, 1'b1, 1'b0, 1'b0);
      wait_done(seen);
      if (seen) start = 1'b1;
      checks++;
      if (!seen || xfer_cnt != 64 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_first got done=%b xfers=%0d left=%0d exp=1/64/0", seen, xfer_cnt, exp_q.size());
      end
      @(posedge clk); #1;
      start = 1'b0;
      send_block(m2, 1'b0, 1'b0, 1'b0);
      wait_done(seen);
      checks++;
      if (!seen || xfer_cnt != 64 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_second got done=%b xfers=%0d left=%0d exp=1/64/0", seen, xfer_cnt, exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      logic [31:0] m [16];
      bit hit;
      for (int i = 0; i < 16; i++) m[i] = $urandom;
      ready_mode = 1;
      send_block(m, 1'b1, 1'b0, 1'b0);
      hit = 1'b0;
      for (int n = 0; n < 100 && !hit; n++) begin
         @(negedge clk);
         if (w_valid && w_idx == 6'd30) hit = 1'b1;
         else begin @(posedge clk); #1; end
      end
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      checks++;
      if (!hit || busy !== 1'b0 || w_valid !== 1'b0 || w_idx !== 6'd0) begin
         failures++;
         $display("FAIL mid_reset got hit=%b busy=%b v=%b idx=%0d exp=1/0/0/0", hit, busy, w_valid, w_idx);
      end
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;
      test_random("after_reset", 1'b0, 1, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_abc();
      test_zero_timing();
      test_random("backpressure", 1'b0, 2, 1'b1);
      test_random("stall_low", 1'b0, 2, 1'b0);
      test_random("overflow", 1'b1, 1, 1'b0);
      test_random("overflow_bp", 1'b1, 2, 1'b1);
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Sequential SHA-256 message-schedule unit. It accepts the 16 words of one 512-bit block, stores them in a 16-word sliding window, and emits W[0]..W[63] in order, one word per accepted transfer. It is the stage that consumes the σ0/σ1 schedule functions and feeds W[t] to the compression round engine downstream.

## Interface
- No parameters. Widths are fixed at word 32, index 6.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begins a new block; honoured only in IDLE.
- msg_valid  input  1  a message word is present on msg_word.
- msg_word  input  32  message word M[t], big-endian word order, t = 0..15.
- msg_ready  output  1  unit accepts msg_word this cycle.
- w_valid  output  1  w_out/w_idx hold a valid schedule word.
- w_out  output  32  schedule word W[w_idx].
- w_idx  output  6  index t of w_out, 0..63.
- w_ready  input  1  downstream consumes w_out this cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after W[63] is consumed.

## Operation
- Window win[0..15] holds 32-bit words. win[0] = W[t-16] and win[15] = W[t-1]. Each produced word shifts in at win[15], and every entry moves down one place.
- Output register: w_out, w_idx, w_valid. out_free = !w_valid | w_ready.
- A transfer on either side occurs when valid & ready are both high at the rising edge.
- Counter t is 7 bits internally and counts words loaded into the output register.
- Expansion formula: W[t] = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], modulo 2^32; carries out of bit 31 are discarded.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- States:
  - IDLE: msg_ready = 0. start = 1 → LOAD, t ← 0.
  - LOAD: msg_ready = out_free, combinational.
    - On a msg transfer: w_out ← msg_word, w_idx ← t, w_valid ← 1, shift msg_word into the window, t ← t+1.
    - The transfer with t = 15 → EXPAND.
  - EXPAND: when out_free, load the formula result into the output register as above and shift it into the window, t ← t+1.
    - The load with t = 63 → DRAIN.
  - DRAIN: wait for the w transfer of W[63], then w_valid ← 0, done ← 1 for one cycle → IDLE.
- Clearing w_valid: in any state, a w transfer with no new load in the same cycle clears w_valid.
- start outside IDLE is ignored, and the block in progress is unaffected.
- msg_valid outside LOAD is ignored. No word is consumed and msg_ready stays 0.

## Timing
- Reset values: every register is 0 and the state is IDLE. This gives w_valid = 0, w_out = 0, w_idx = 0, msg_ready = 0, busy = 0, done = 0, window all-zero, t = 0.
- Asserting rst_n low mid-block aborts the block immediately. After release the unit is in IDLE, and the next start loads a fresh block.
- start is sampled at edge S. msg_ready can be high in cycle S+1.
- Each word is registered one cycle after its input transfer: W[t] is visible on w_out the cycle after M[t] is accepted.
- With msg_valid = 1 and w_ready = 1 held, there is one word per cycle and no bubble:
  - W[15] registers at edge E.
  - W[16] registers at edge E+1.
  - W[63] registers at E+48.
  - done is high in the cycle after the W[63] transfer.
- Backpressure: when w_valid = 1 and w_ready = 0, w_out, w_idx and the window hold unchanged, and msg_ready = 0.
- A consume and a new load in the same cycle are one transfer: w_valid stays 1 and the register is replaced.
- busy rises the cycle after start and falls in the same cycle that done is high.

## Test plan
- Reset: drive rst_n low with random inputs → all outputs 0 and msg_ready = 0. Pulse rst_n low mid-EXPAND at w_idx = 30 → after release, busy = 0, w_valid = 0, and a subsequent block is correct.
- "abc" block (M0 = 0x61626380, M1..M14 = 0, M15 = 0x00000018), w_ready = 1:
  - W[0..15] echo the input words.
  - W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405, W19 = 0x600003C6.
  - W[16..63] match the reference model.
  - Exactly 64 transfers, w_idx 0..63, then one done pulse.
- All-zero block → all 64 W words are 0x00000000. Run with msg_valid = 1 and w_ready = 1 held and check W[63] registers 48 cycles after W[15].
- Random backpressure: w_ready toggled pseudo-randomly and msg_valid gapped → w_out and w_idx are stable while stalled, no word is lost or duplicated, and the sequence matches the model.
- Overflow: all M = 0xFFFFFFFF → each W wraps modulo 2^32 and matches the model.
- start pulsed during LOAD and during EXPAND → ignored and the current output sequence is unchanged. Two back-to-back blocks with start asserted in the done cycle's IDLE follow-on → both blocks are correct.
